alu_bus_datapath: RTL and testbench
===================================

// Module: alu_bus_datapath
// PURPOSE
//  Responder end of the ALU control-strobe interface: general registers R0-R4, ALU input
//  latches A/B, ALU output latch Y and shared 16-bit bus mux, driven purely by the
//  ALU control FSM strobes (rxOut, rxIn, ALUin0, ALUin1, ALUoutlatch, ALUoutEN, done).
//  Sits beside the ALU control FSM in the microcontroller core; flags strobe protocol violations.
// PARAMETERS
//  W      16  data/bus width
//  CNT_W  16  width of completed-operation counter
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  opcode       in   4   instruction[15:12], sampled when ALUoutlatch=1
//  rxOut        in   5   one-hot reg->bus enable; bit4=R0 ... bit0=R4
//  rxIn         in   5   one-hot bus->reg load; bit4=R0 ... bit0=R4
//  ALUin0       in   1   load A from bus
//  ALUin1       in   1   load B from bus
//  ALUoutlatch  in   1   load Y (and flags) from ALU result
//  ALUoutEN     in   1   drive Y onto bus
//  done         in   1   operation-complete pulse
//  ext_we       in   1   external register write (program load)
//  ext_sel      in   3   external write target 0..4; 5..7 ignored
//  ext_data     in   W   external write data
//  bus          out  W   shared bus value (combinational)
//  dbg_r0..r4   out  W   register contents
//  bus_err      out  1   sticky protocol-violation flag
//  op_count     out  CNT_W  completed operations, saturating
//  flags        out  3   {N,C,Z} of last latched result
// BEHAVIOUR
//  - Reset (rst=1 at edge): R0-R4, A, B, Y, flags, op_count = 0; bus_err = 0.
//  - Bus drivers: ALUoutEN plus each rxOut bit. Exactly one asserted -> bus = that source;
//    none -> bus = 0; more than one -> bus = 0 and bus_err sets at the next edge.
//  - rxIn: single bit -> that reg <= bus at edge; visible on bus/dbg next cycle.
//    >1 bit -> no write, bus_err sets. rxIn to reg k while rxOut selects reg k is legal (holds value).
//  - ext_we to same reg as rxIn in same cycle: rxIn wins, ext write dropped. ext_sel>4: no write.
//  - ALUin0/ALUin1: A/B <= bus at edge; both high same cycle -> both load same value.
//  - ALU (combinational on A,B,opcode): 1000 ADD, 1001 SUB(A-B), 1010 AND, 1011 OR,
//    1100 XOR, 1101 NOT A, 1110 SHL A by 1; any other opcode -> result 0. W-bit wrap-around.
//  - ALUoutlatch: Y <= result at edge. Latency A/B load -> Y valid: 1 edge after ALUoutlatch.
//  - Simultaneous ALUoutlatch and ALUoutEN: bus shows old Y this cycle; new Y next cycle.
//  - done=1 at edge: op_count++ ; saturates at 2^CNT_W-1 (no wrap).
//  - bus_err clears only on rst. Reset mid-operation discards all partial state.
// CONFIGURATION
//  ALU_FLAGS_EN defined: on ALUoutlatch, Z=(result==0), N=result[W-1],
//    C=carry-out (ADD), borrow (SUB, A<B unsigned), shifted-out bit (SHL), 0 otherwise.
//  Not defined: flags tied to 3'b000; no flag registers generated.
// STRUCTURE
//  Package alu_bus_pkg: opcode constants (OP_ADD..OP_SHL), one-hot reg selects
//    (RX_R0=5'b10000 .. RX_R4=5'b00001), W default.
//  Sub-module alu_core: combinational ALU (opcode, A, B -> result, carry); no state.
// TESTING
//  1 ext write R0=0x0005, R1=0x0003; ADD strobe sequence R0,R1 -> R0 = 0x0008, op_count=1.
//  2 SUB R1-R0 with R1=3,R0=5 -> result 0xFFFE; with ALU_FLAGS_EN flags N=1,C=1,Z=0.
//  3 rxOut=5'b10100 -> bus=0, bus_err=1 next cycle, stays 1 until rst.
//  4 rxIn=5'b00011 with bus=0x1234 -> R3,R4 unchanged, bus_err=1.
//  5 ext_we R2=0xAAAA with rxIn=R2 bus=0x5555 same edge -> R2=0x5555.
//  6 rst asserted between ALUin1 and ALUoutlatch -> all regs/Y/op_count 0, bus=0.

Source files
------------

// File: rtl/alu_bus_pkg.sv
// Shared constants for the ALU bus datapath.
//  - W_DEF      : default data/bus width
//  - NUM_REGS   : number of general registers (R0..R4)
//  - OP_*       : ALU opcodes, as carried in instruction[15:12]
//  - RX_R*      : one-hot rxOut/rxIn selects (R0 is the MSB)
package alu_bus_pkg;

   localparam int unsigned W_DEF    = 16;
   localparam int unsigned NUM_REGS = 5;

   localparam logic [3:0] OP_ADD = 4'b1000;
   localparam logic [3:0] OP_SUB = 4'b1001;
   localparam logic [3:0] OP_AND = 4'b1010;
   localparam logic [3:0] OP_OR  = 4'b1011;
   localparam logic [3:0] OP_XOR = 4'b1100;
   localparam logic [3:0] OP_NOT = 4'b1101;
   localparam logic [3:0] OP_SHL = 4'b1110;

   localparam logic [4:0] RX_R0 = 5'b10000;
   localparam logic [4:0] RX_R1 = 5'b01000;
   localparam logic [4:0] RX_R2 = 5'b00100;
   localparam logic [4:0] RX_R3 = 5'b00010;
   localparam logic [4:0] RX_R4 = 5'b00001;

endpackage

// File: rtl/alu_bus_datapath_if.sv
// Strobe interface between the ALU control FSM (master) and the bus datapath (slave).
//  opcode       : instruction[15:12], used when ALUoutlatch is high
//  rxOut / rxIn : one-hot register->bus enable / bus->register load (bit4 = R0)
//  ALUin0/1     : load A / B from the bus
//  ALUoutlatch  : load Y from the ALU result
//  ALUoutEN     : drive Y onto the bus
//  done         : operation-complete pulse
//  bus          : shared bus value, driven by the datapath
interface alu_bus_datapath_if #(
   parameter int unsigned W = alu_bus_pkg::W_DEF
);
   logic [3:0]   opcode;
   logic [4:0]   rxOut;
   logic [4:0]   rxIn;
   logic         ALUin0;
   logic         ALUin1;
   logic         ALUoutlatch;
   logic         ALUoutEN;
   logic         done;
   logic [W-1:0] bus;

   modport master (
      output opcode, rxOut, rxIn, ALUin0, ALUin1, ALUoutlatch, ALUoutEN, done,
      input  bus
   );

   modport slave (
      input  opcode, rxOut, rxIn, ALUin0, ALUin1, ALUoutlatch, ALUoutEN, done,
      output bus
   );
endinterface

// File: rtl/alu_bus_datapath_alu_core.sv
// Combinational ALU, no state.
//  opcode : operation select (OP_ADD..OP_SHL, anything else yields 0)
//  a, b   : operands
//  result : W-bit wrap-around result
//  carry  : carry-out (ADD), borrow (SUB), shifted-out bit (SHL), else 0
module alu_core
   import alu_bus_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic [3:0]   opcode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result,
   output logic         carry
);

   logic [W:0] wide;

   always_comb begin
      wide   = '0;
      result = '0;
      carry  = 1'b0;
      case (opcode)
         OP_ADD: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[W-1:0];
            carry  = wide[W];
         end
         OP_SUB: begin
            // MSB of the extended difference is set exactly when a < b (unsigned).
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[W-1:0];
            carry  = wide[W];
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         OP_SHL: begin
            result = {a[W-2:0], 1'b0};
            carry  = a[W-1];
         end
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_bus_datapath.sv
// Responder end of the ALU control-strobe interface: registers R0..R4, ALU input latches
// A/B, output latch Y and the shared bus mux. Flags strobe protocol violations.
// Optional feature: define ALU_FLAGS_EN to build the {N,C,Z} flag register; otherwise
// flags is tied to zero.
//  clk, rst        : clock, synchronous active-high reset
//  sbus            : strobe interface (slave modport), drives sbus.bus
//  ext_we/sel/data : external register write (program load), sel 5..7 ignored
//  dbg_r0..dbg_r4  : register contents
//  bus_err         : sticky protocol-violation flag
//  op_count        : saturating count of done pulses
//  flags           : {N,C,Z} of the last latched result
module alu_bus_datapath
   import alu_bus_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   alu_bus_datapath_if.slave   sbus,
   input  logic                ext_we,
   input  logic [2:0]          ext_sel,
   input  logic [W-1:0]        ext_data,
   output logic [W-1:0]        dbg_r0,
   output logic [W-1:0]        dbg_r1,
   output logic [W-1:0]        dbg_r2,
   output logic [W-1:0]        dbg_r3,
   output logic [W-1:0]        dbg_r4,
   output logic                bus_err,
   output logic [CNT_W-1:0]    op_count,
   output logic [2:0]          flags
);

   logic [W-1:0]     regs_q [NUM_REGS];
   logic [W-1:0]     a_q, b_q, y_q;
   logic [W-1:0]     bus_val;
   logic [W-1:0]     alu_result;
   logic             alu_carry;
   logic [CNT_W-1:0] op_count_q;
   logic             bus_err_q;
   logic [NUM_REGS:0] drivers;
   logic             drive_multi;
   logic             rx_in_one;
   logic             rx_in_multi;
   logic             ext_hit;

   // Every bus source in one vector so contention is a simple popcount.
   assign drivers     = {sbus.rxOut, sbus.ALUoutEN};
   assign drive_multi = ($countones(drivers) > 1);
   assign rx_in_one   = $onehot(sbus.rxIn);
   assign rx_in_multi = ($countones(sbus.rxIn) > 1);
   assign ext_hit     = ext_we && (ext_sel < 3'(NUM_REGS));

   // Contention forces the bus to zero rather than picking a winner.
   always_comb begin
      bus_val = '0;
      if (!drive_multi) begin
         if (sbus.ALUoutEN) bus_val = y_q;
         for (int k = 0; k < NUM_REGS; k++) begin
            if (sbus.rxOut[NUM_REGS-1-k]) bus_val = regs_q[k];
         end
      end
   end

   assign sbus.bus = bus_val;

   alu_core #(
      .W (W)
   ) u_alu_core (
      .opcode (sbus.opcode),
      .a      (a_q),
      .b      (b_q),
      .result (alu_result),
      .carry  (alu_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
         a_q        <= '0;
         b_q        <= '0;
         y_q        <= '0;
         op_count_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         // A bus load to a register takes priority over an external write to it.
         for (int k = 0; k < NUM_REGS; k++) begin
            if (rx_in_one && sbus.rxIn[NUM_REGS-1-k]) begin
               regs_q[k] <= bus_val;
            end else if (ext_hit && (ext_sel == 3'(k))) begin
               regs_q[k] <= ext_data;
            end
         end
         if (sbus.ALUin0)      a_q <= bus_val;
         if (sbus.ALUin1)      b_q <= bus_val;
         if (sbus.ALUoutlatch) y_q <= alu_result;
         if (sbus.done && (op_count_q != '1)) op_count_q <= op_count_q + 1'b1;
         if (drive_multi || rx_in_multi) bus_err_q <= 1'b1;
      end
   end

`ifdef ALU_FLAGS_EN
   logic [2:0] flags_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 3'b000;
      end else if (sbus.ALUoutlatch) begin
         flags_q <= {alu_result[W-1], alu_carry, (alu_result == '0)};
      end
   end

   assign flags = flags_q;
`else
   logic unused_carry;
   assign unused_carry = alu_carry;
   assign flags        = 3'b000;
`endif

   assign dbg_r0   = regs_q[0];
   assign dbg_r1   = regs_q[1];
   assign dbg_r2   = regs_q[2];
   assign dbg_r3   = regs_q[3];
   assign dbg_r4   = regs_q[4];
   assign bus_err  = bus_err_q;
   assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_bus_datapath.sv
// Randomized scoreboard bench for alu_bus_datapath. Expected bus values are queued when
// ALUoutEN is issued and popped by a monitor; register/counter/flag state is compared
// against a behavioural model. CNT_W is set to 4 so counter saturation is reached.
module tb_alu_bus_datapath;
   import alu_bus_pkg::*;

   localparam int unsigned W     = 16;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned CMAX  = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic             ext_we;
   logic [2:0]       ext_sel;
   logic [W-1:0]     ext_data;
   logic [W-1:0]     dbg_r0, dbg_r1, dbg_r2, dbg_r3, dbg_r4;
   logic             bus_err;
   logic [CNT_W-1:0] op_count;
   logic [2:0]       flags;

   alu_bus_datapath_if #(.W(W)) sbus ();

   alu_bus_datapath #(
      .W     (W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sbus     (sbus),
      .ext_we   (ext_we),
      .ext_sel  (ext_sel),
      .ext_data (ext_data),
      .dbg_r0   (dbg_r0),
      .dbg_r1   (dbg_r1),
      .dbg_r2   (dbg_r2),
      .dbg_r3   (dbg_r3),
      .dbg_r4   (dbg_r4),
      .bus_err  (bus_err),
      .op_count (op_count),
      .flags    (flags)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int unsigned exp_bus_q[$];

   // Behavioural model state.
   int unsigned m_regs[5];
   int unsigned m_a, m_b, m_y, m_count;
   logic [2:0]  m_flags;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   function automatic logic [4:0] oh(input int k);
      logic [4:0] top;
      top = 5'b10000;
      return top >> k;
   endfunction

   function automatic int unsigned get_dbg(input int k);
      case (k)
         0: return dbg_r0;
         1: return dbg_r1;
         2: return dbg_r2;
         3: return dbg_r3;
         default: return dbg_r4;
      endcase
   endfunction

   function automatic int unsigned ref_alu(input logic [3:0] op, input int unsigned a,
                                           input int unsigned b, output logic c);
      int unsigned s;
      c = 1'b0;
      case (op)
         4'h8: begin s = a + b; c = (s > 32'hFFFF); return s & 32'hFFFF; end
         4'h9: begin c = (a < b); return (a - b) & 32'hFFFF; end
         4'hA: return a & b;
         4'hB: return a | b;
         4'hC: return a ^ b;
         4'hD: return (~a) & 32'hFFFF;
         4'hE: begin c = ((a >> 15) & 1) == 1; return (a << 1) & 32'hFFFF; end
         default: return 0;
      endcase
   endfunction

   task automatic model_latch(input logic [3:0] op);
      logic c;
      m_y = ref_alu(op, m_a, m_b, c);
`ifdef ALU_FLAGS_EN
      m_flags = {(m_y >= 32'h8000), c, (m_y == 0)};
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sbus.opcode      = 4'h0;
      sbus.rxOut       = 5'b0;
      sbus.rxIn        = 5'b0;
      sbus.ALUin0      = 1'b0;
      sbus.ALUin1      = 1'b0;
      sbus.ALUoutlatch = 1'b0;
      sbus.ALUoutEN    = 1'b0;
      sbus.done        = 1'b0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 5; k++) m_regs[k] = 0;
      m_a = 0; m_b = 0; m_y = 0; m_count = 0; m_flags = 3'b000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      ext_we = 1'b0;
      step();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic ext_write(input int sel, input int unsigned data);
      ext_we   = 1'b1;
      ext_sel  = 3'(sel);
      ext_data = W'(data);
      step();
      ext_we = 1'b0;
      if (sel <= 4) m_regs[sel] = data & 32'hFFFF;
   endtask

   task automatic do_op(input int sa, input int sb, input logic [3:0] op, input int dst);
      sbus.rxOut = oh(sa); sbus.ALUin0 = 1'b1; step(); m_a = m_regs[sa]; idle();
      sbus.rxOut = oh(sb); sbus.ALUin1 = 1'b1; step(); m_b = m_regs[sb]; idle();
      sbus.opcode = op; sbus.ALUoutlatch = 1'b1; step(); model_latch(op); idle();
      exp_bus_q.push_back(m_y);
      sbus.ALUoutEN = 1'b1; sbus.rxIn = oh(dst); sbus.done = 1'b1;
      step();
      m_regs[dst] = m_y;
      if (m_count < CMAX) m_count++;
      idle();
   endtask

   task automatic check_all_regs(input string tag);
      for (int k = 0; k < 5; k++) check($sformatf("%s_r%0d", tag, k), get_dbg(k), m_regs[k]);
   endtask

   // Monitor: whenever Y is driven onto the bus, compare against the next queued value.
   always @(negedge clk) begin
      if (!rst && sbus.ALUoutEN) begin
         if (exp_bus_q.size() == 0) begin
            n_checks++;
            $display("FAIL bus_unexpected: got 0x%0h, want no ALUoutEN", sbus.bus);
         end else begin
            check("bus_y", sbus.bus, exp_bus_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] op;
      rst = 1'b1; idle(); ext_we = 1'b0; ext_sel = 3'd0; ext_data = '0;
      step(); step();
      rst = 1'b0;
      model_reset();

      // Reset state.
      check_all_regs("rst");
      check("rst_bus", sbus.bus, 0);
      check("rst_bus_err", bus_err, 0);
      check("rst_op_count", op_count, 0);
      check("rst_flags", flags, 0);

      // ADD R0+R1 -> R0.
      ext_write(0, 32'h0005);
      ext_write(1, 32'h0003);
      do_op(0, 1, OP_ADD, 0);
      check("add_r0", dbg_r0, 32'h0008);
      check("add_op_count", op_count, 1);

      // SUB R1-R0 with R1=3, R0=5 (after reloading R0).
      ext_write(0, 32'h0005);
      do_op(1, 0, OP_SUB, 2);
      check("sub_r2", dbg_r2, 32'hFFFE);
`ifdef ALU_FLAGS_EN
      check("sub_flags", flags, 3'b110);
`else
      check("sub_flags", flags, 3'b000);
`endif

      // Latch and drive in the same cycle: old Y now, new Y next cycle.
      exp_bus_q.push_back(m_y);
      sbus.opcode = OP_XOR; sbus.ALUoutlatch = 1'b1; sbus.ALUoutEN = 1'b1;
      step();
      model_latch(OP_XOR);
      idle();
      exp_bus_q.push_back(m_y);
      sbus.ALUoutEN = 1'b1;
      step();
      idle();
      check("xor_flags", flags, m_flags);

      // Randomized operations, including undefined opcodes and ignored ext_sel values.
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 1) ext_write($urandom_range(0, 7), $urandom & 32'hFFFF);
         op = 4'($urandom_range(0, 15));
         do_op($urandom_range(0, 4), $urandom_range(0, 4), op, $urandom_range(0, 4));
         check($sformatf("rand%0d_count", i), op_count, m_count);
         check($sformatf("rand%0d_flags", i), flags, m_flags);
      end
      check_all_regs("rand");
      check("rand_bus_err", bus_err, 0);

      // rxIn beats ext write to the same register; ext_sel 5 writes nothing.
      ext_write(0, 32'h5555);
      sbus.rxOut = RX_R0; sbus.rxIn = RX_R2;
      ext_we = 1'b1; ext_sel = 3'd2; ext_data = 16'hAAAA;
      step();
      idle(); ext_we = 1'b0;
      m_regs[2] = 32'h5555;
      check("prio_r2", dbg_r2, 32'h5555);
      ext_write(5, 32'hBEEF);
      check_all_regs("sel5");
      check("legal_bus_err", bus_err, 0);

      // Multi-bit rxIn: no write, error set and sticky.
      ext_write(1, 32'h1234);
      sbus.rxOut = RX_R1; sbus.rxIn = 5'b00011;
      step();
      idle();
      check("multi_in_r3", dbg_r3, m_regs[3]);
      check("multi_in_r4", dbg_r4, m_regs[4]);
      check("multi_in_err", bus_err, 1);
      step();
      check("multi_in_err_sticky", bus_err, 1);

      do_reset();
      check("reset_clears_err", bus_err, 0);

      // Bus contention: bus reads 0, error next cycle, stays until reset.
      ext_write(0, 32'h1111);
      ext_write(2, 32'h2222);
      sbus.rxOut = 5'b10100;
      #1;
      check("contend_bus", sbus.bus, 0);
      check("contend_err_before", bus_err, 0);
      step();
      idle();
      check("contend_err", bus_err, 1);
      step(); step(); step();
      check("contend_err_sticky", bus_err, 1);

      // Reset between ALUin1 and ALUoutlatch discards everything.
      do_reset();
      ext_write(0, 32'h0007);
      ext_write(1, 32'h0009);
      sbus.rxOut = RX_R0; sbus.ALUin0 = 1'b1; step(); idle();
      sbus.rxOut = RX_R1; sbus.ALUin1 = 1'b1; step(); idle();
      do_reset();
      check_all_regs("midrst");
      check("midrst_count", op_count, 0);
      check("midrst_bus", sbus.bus, 0);
      sbus.opcode = OP_ADD; sbus.ALUoutlatch = 1'b1; step(); idle();
      exp_bus_q.push_back(0);
      sbus.ALUoutEN = 1'b1; step(); idle();

      check("queue_drained", exp_bus_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
